hazard_stall_ctl: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS core; generates the `stall` inputs consumed by the stallable pipeline registers and the bubble/flush controls for IF/ID and ID/EX.
- Detects load-use hazards and taken-branch flushes.
- Owns the multi-cycle mult/div sequencer (busy counter, HI/LO write pulse) and holds the front end while a dependent instruction waits.

---
 rtl/hazard_stall_ctl.sv | 97 +++++++++
 tb/tb_hazard_stall_ctl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctl.sv
// Hazard controller for the 5-stage MIPS core: load-use stalls, taken-branch flushes, mult/div sequencing.
// Optional stall-cycle performance counter enabled by defining HAZARD_STALL_CTL_PERF_EN.
module hazard_stall_ctl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CW          = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic [4:0] ex_rt,
  input  logic       ex_memread,
  input  logic       ex_branch_taken,
  input  logic       id_md_start,
  input  logic       id_md_is_div,
  input  logic       id_md_read,
  output logic       stall_pc,
  output logic       stall_ifid,
  output logic       flush_ifid,
  output logic       flush_idex,
  output logic       md_busy,
  output logic       md_done
`ifdef HAZARD_STALL_CTL_PERF_EN
  ,
  output logic [15:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter is loaded with latency-2 so the op spends latency-1 cycles in BUSY and one in DONE.
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 2);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 2);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          lu, mdh, hz;

  assign md_busy = (state != IDLE);
  assign md_done = (state == DONE);

  assign lu  = ex_memread && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign mdh = md_busy && (id_md_read || id_md_start);
  // A taken branch squashes whatever is in ID, so it never needs to wait.
  assign hz  = (lu || mdh) && !ex_branch_taken;

  assign stall_pc   = hz;
  assign stall_ifid = hz;
  assign flush_idex = hz || ex_branch_taken;
  assign flush_ifid = ex_branch_taken;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (id_md_start && !hz && !ex_branch_taken) begin
          cnt_nxt   = id_md_is_div ? DIV_LOAD : MULT_LOAD;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) state_nxt = DONE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef HAZARD_STALL_CTL_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                                stall_cycles <= '0;
    else if (hz && (stall_cycles != 16'hFFFF)) stall_cycles <= stall_cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctl.sv
// Self-checking bench for hazard_stall_ctl: per-cycle model comparison plus directed literal checks.
module tb_hazard_stall_ctl;
  localparam int MULT = 4;
  localparam int DIV  = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_memread, ex_branch_taken;
  logic       id_md_start, id_md_is_div, id_md_read;
  logic       stall_pc, stall_ifid, flush_ifid, flush_idex, md_busy, md_done;
`ifdef HAZARD_STALL_CTL_PERF_EN
  logic [15:0] stall_cycles;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hazard_stall_ctl #(.MULT_CYCLES(MULT), .DIV_CYCLES(DIV), .CW(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rt(ex_rt), .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
    .id_md_start(id_md_start), .id_md_is_div(id_md_is_div), .id_md_read(id_md_read),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .md_busy(md_busy), .md_done(md_done)
`ifdef HAZARD_STALL_CTL_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: the unit is occupied on absolute cycles [m_bs, m_be]; m_be is the HI/LO write cycle.
  int  cyc = 0;
  bit  m_ok = 0;
  bit  m_valid = 0;
  int  m_bs, m_be;
  int  m_perf = 0;

  function automatic bit m_busy();
    return m_valid && (cyc >= m_bs) && (cyc <= m_be);
  endfunction

  function automatic bit m_hz();
    bit lu_e, mdh_e;
    lu_e  = ex_memread && (ex_rt != 0) &&
            ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    mdh_e = m_busy() && (id_md_read || id_md_start);
    return (lu_e || mdh_e) && !ex_branch_taken;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ok    = 1;
      m_valid = 0;
      m_perf  = 0;
    end else begin
      if (m_hz() && m_perf < 16'hFFFF) m_perf = m_perf + 1;
      if (!m_busy() && id_md_start && !m_hz() && !ex_branch_taken) begin
        m_valid = 1;
        m_bs    = cyc + 1;
        m_be    = cyc + (id_md_is_div ? DIV : MULT);
      end
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("stall_pc",   stall_pc,   m_hz());
      check("stall_ifid", stall_ifid, m_hz());
      check("flush_idex", flush_idex, m_hz() || ex_branch_taken);
      check("flush_ifid", flush_ifid, ex_branch_taken);
      check("md_busy",    md_busy,    m_busy());
      check("md_done",    md_done,    m_valid && cyc == m_be);
`ifdef HAZARD_STALL_CTL_PERF_EN
      check("stall_cycles", stall_cycles, m_perf);
`endif
    end
  end

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    ex_rt = 5'd0; ex_memread = 1'b0; ex_branch_taken = 1'b0;
    id_md_start = 1'b0; id_md_is_div = 1'b0; id_md_read = 1'b0;
  endtask

  task automatic end_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    end_cycle();
    end_cycle();
    @(negedge clk);
    check("reset_busy", md_busy, 1'b0);
    check("reset_done", md_done, 1'b0);
    end_cycle();
    rst_n = 1'b1;

    // Load-use on rs, then the same with $zero as destination.
    ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    @(negedge clk);
    check("lu_stall_pc", stall_pc, 1'b1);
    check("lu_stall_ifid", stall_ifid, 1'b1);
    check("lu_flush_idex", flush_idex, 1'b1);
    check("lu_flush_ifid", flush_ifid, 1'b0);
    end_cycle();
    ex_rt = 5'd0; id_rs = 5'd0;
    @(negedge clk);
    check("lu_r0_stall", stall_pc, 1'b0);
    check("lu_r0_flush_idex", flush_idex, 1'b0);
    end_cycle();

    // rt comparison only counts when ID reads rt.
    ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b0;
    @(negedge clk);
    check("rt_unused", stall_pc, 1'b0);
    end_cycle();
    id_uses_rt = 1'b1;
    @(negedge clk);
    check("rt_used", stall_pc, 1'b1);
    end_cycle();
    idle_inputs();

    // Mult issue at cycle 0, mfhi waiting in ID from cycle 1.
    id_md_start = 1'b1; id_md_is_div = 1'b0;
    @(negedge clk);
    check("mult_issue_nostall", stall_pc, 1'b0);
    end_cycle();
    id_md_start = 1'b0; id_md_read = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("mult_busy_c%0d", k), md_busy, (k <= 4));
      check($sformatf("mult_done_c%0d", k), md_done, (k == 4));
      check($sformatf("mfhi_stall_c%0d", k), stall_pc, (k <= 4));
      end_cycle();
    end
    idle_inputs();

    // Div followed by a dependent div; a load-use overlaps the mult/div stall at cycle 5.
    id_md_start = 1'b1; id_md_is_div = 1'b1;
    @(negedge clk);
    check("div_issue_nostall", stall_pc, 1'b0);
    end_cycle();
    for (int k = 1; k <= 33; k++) begin
      if (k == 5) begin ex_memread = 1'b1; ex_rt = 5'd4; id_rs = 5'd4; end
      if (k == 6) begin ex_memread = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; end
      @(negedge clk);
      check($sformatf("div2_stall_c%0d", k), stall_pc, (k <= 32));
      check($sformatf("div_done_c%0d", k), md_done, (k == 32));
      end_cycle();
    end
    idle_inputs();

    // Second div is now in its cycle 1; reset it at cycle 10.
    for (int k = 1; k <= 9; k++) end_cycle();
    @(negedge clk);
    check("div2_busy_c10", md_busy, 1'b1);
    rst_n = 1'b0;
    end_cycle();
    rst_n = 1'b1;
    id_md_read = 1'b1;
    @(negedge clk);
    check("rst_abort_busy", md_busy, 1'b0);
    check("rst_abort_mfhi", stall_pc, 1'b0);
    end_cycle();
    idle_inputs();

    // Taken branch beats both load-use and mult/div issue.
    ex_branch_taken = 1'b1; ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    id_md_start = 1'b1;
    @(negedge clk);
    check("br_stall_pc", stall_pc, 1'b0);
    check("br_flush_ifid", flush_ifid, 1'b1);
    check("br_flush_idex", flush_idex, 1'b1);
    end_cycle();
    idle_inputs();
    @(negedge clk);
    check("br_no_start", md_busy, 1'b0);
    end_cycle();

    // Branch while busy releases a waiting mfhi.
    id_md_start = 1'b1;
    end_cycle();
    id_md_start = 1'b0; id_md_read = 1'b1; ex_branch_taken = 1'b1;
    @(negedge clk);
    check("br_busy_busy", md_busy, 1'b1);
    check("br_busy_stall", stall_pc, 1'b0);
    end_cycle();
    idle_inputs();
    repeat (6) end_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
